// File: rtl/cdc_rd_arbiter_pkg.sv
// Shared definitions for the CDC read arbiter: FSM encoding, width constants, round-robin step.
package cdc_rd_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int BEAT_CNT_W = 8;

  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int rr_next(input int idx, input int num_ch);
    return (idx + 1) % num_ch;
  endfunction

endpackage

// File: rtl/cdc_rd_arbiter_rr_sel.sv
// Round-robin channel selector, purely combinational: searches upward from ptr+1.
// With prioEn, channel 0 wins outright and the others rotate among themselves.
module cdc_rd_arbiter_rr_sel
  import cdc_rd_arbiter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  input  logic              prioEn,
  output logic [CH_W-1:0]   grant,
  output logic              found
);

  logic [NUM_CH-1:0] req_rr;
  int                cand;

  always_comb begin
    req_rr = req;
    grant  = '0;
    found  = 1'b0;
    cand   = int'(ptr);
    if (prioEn) begin
      req_rr[0] = 1'b0;
      found     = req[0];
    end
    for (int k = 0; k < NUM_CH; k++) begin
      cand = rr_next(cand, NUM_CH);
      if (!found && req_rr[cand[CH_W-1:0]]) begin
        found = 1'b1;
        grant = cand[CH_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cdc_rd_arbiter.sv
// Merges NUM_CH CDC FIFO read channels into one registered beat stream; grant->chReady 1 cycle, beat->outValid 1 cycle.
// Stalls on !outReady while holding the output beat; channel 0 priority when CDC_RD_ARB_PRIO_EN is defined.
module cdc_rd_arbiter
  import cdc_rd_arbiter_pkg::*;
#(
  parameter int  NUM_CH     = 4,
  parameter int  DATA_WIDTH = 32,
  parameter int  MAX_BURST  = 8,
  parameter int  FAMILY     = 16,
  localparam int CH_W       = ch_width(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         terminate,
  input  logic [NUM_CH-1:0]            chValid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] chData,
  input  logic [NUM_CH-1:0]            chLast,
  output logic [NUM_CH-1:0]            chReady,
  output logic                         outValid,
  output logic [DATA_WIDTH-1:0]        outData,
  output logic                         outLast,
  output logic [CH_W-1:0]              outCh,
  input  logic                         outReady,
  output logic                         busy
);

  if (NUM_CH < 2 || NUM_CH > 8 || MAX_BURST < 1 || MAX_BURST > 255 || FAMILY < 0) begin : g_param_check
    $error("cdc_rd_arbiter: parameter out of legal range");
  end

`ifdef CDC_RD_ARB_PRIO_EN
  localparam logic PRIO_EN = 1'b1;
`else
  localparam logic PRIO_EN = 1'b0;
`endif

  arb_state_e             state_q;
  logic [CH_W-1:0]        ptr_q;
  logic [CH_W-1:0]        grant_q;
  logic [BEAT_CNT_W-1:0]  beat_cnt_q;
  logic [BEAT_CNT_W-1:0]  beat_cnt_d;
  logic                   out_valid_q;
  logic [DATA_WIDTH-1:0]  out_data_q;
  logic                   out_last_q;
  logic [CH_W-1:0]        out_ch_q;

  logic [CH_W-1:0]        sel_grant;
  logic                   sel_found;
  logic                   beat_ok;
  logic                   accept;
  logic                   grant_last;
  logic                   burst_end;
  logic [DATA_WIDTH-1:0]  grant_data;

  cdc_rd_arbiter_rr_sel #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr_sel (
    .req    (chValid),
    .ptr    (ptr_q),
    .prioEn (PRIO_EN),
    .grant  (sel_grant),
    .found  (sel_found)
  );

  // rst gates chReady so an abandoned burst never pulls another beat during reset.
  assign beat_ok    = (state_q == ST_GRANT) & (!out_valid_q | outReady) & !terminate & rst;
  assign accept     = chValid[grant_q] & beat_ok;
  assign grant_last = chLast[grant_q];
  assign grant_data = chData[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
  assign burst_end  = grant_last | (beat_cnt_q == BEAT_CNT_W'(MAX_BURST - 1));
  assign beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);

  always_comb begin
    chReady          = '0;
    chReady[grant_q] = beat_ok;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= CH_W'(NUM_CH - 1);
      grant_q     <= '0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else if (terminate) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= grant_data;
        out_last_q  <= grant_last;
        out_ch_q    <= grant_q;
      end else if (outReady) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (sel_found) begin
            state_q    <= ST_GRANT;
            grant_q    <= sel_grant;
            beat_cnt_q <= '0;
            // A priority win by channel 0 must not disturb the rotation of the others.
            if (!(PRIO_EN && sel_grant == '0)) ptr_q <= sel_grant;
          end
        end
        ST_GRANT: begin
          if (accept) begin
            beat_cnt_q <= beat_cnt_d;
            if (burst_end) state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign outValid = out_valid_q;
  assign outData  = out_data_q;
  assign outLast  = out_last_q;
  assign outCh    = out_ch_q;
  assign busy     = (state_q == ST_GRANT);

endmodule

// File: tb/tb_cdc_rd_arbiter.sv
// Bench for cdc_rd_arbiter: directed arbitration scenarios plus a randomized run against
// per-channel sequence scoreboards and a burst-boundary model.
module tb_cdc_rd_arbiter;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int MB  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, terminate, outReady;
  logic [NCH-1:0]    chValid, chLast, chReady;
  logic [NCH*DW-1:0] chData;
  logic              outValid, outLast, busy;
  logic [DW-1:0]     outData;
  logic [1:0]        outCh;

  logic              b_terminate, b_outReady;
  logic [NCH-1:0]    b_chValid, b_chLast, b_chReady;
  logic [NCH*DW-1:0] b_chData;
  logic              b_outValid, b_outLast, b_busy;
  logic [DW-1:0]     b_outData;
  logic [1:0]        b_outCh;

  cdc_rd_arbiter #(.NUM_CH(NCH), .DATA_WIDTH(DW), .MAX_BURST(MB), .FAMILY(16)) dut (
    .clk(clk), .rst(rst), .terminate(terminate), .chValid(chValid), .chData(chData),
    .chLast(chLast), .chReady(chReady), .outValid(outValid), .outData(outData),
    .outLast(outLast), .outCh(outCh), .outReady(outReady), .busy(busy)
  );

  cdc_rd_arbiter #(.NUM_CH(NCH), .DATA_WIDTH(DW), .MAX_BURST(1), .FAMILY(16)) dut_b1 (
    .clk(clk), .rst(rst), .terminate(b_terminate), .chValid(b_chValid), .chData(b_chData),
    .chLast(b_chLast), .chReady(b_chReady), .outValid(b_outValid), .outData(b_outData),
    .outLast(b_outLast), .outCh(b_outCh), .outReady(b_outReady), .busy(b_busy)
  );

  // Each channel is a source emitting an incrementing sequence number tagged with its index.
  logic [23:0]    src_seq [NCH] = '{default: 24'd0};
  logic [23:0]    exp_seq [NCH];
  int             hs_cnt  [NCH];
  logic           last_auto;
  logic [NCH-1:0] last_man;
  int             n_checks, n_pass, n_fail;
  bit             check_burst, open;
  int             cur_ch, run_len, hs0;
  int             obs_q[$], exp_q[$];

  function automatic logic last_of(input int ch, input logic [23:0] s);
    return ((int'(s) + 3 * ch) % 11) == 10;
  endfunction

  always_comb begin
    chData = '0;
    chLast = '0;
    for (int i = 0; i < NCH; i++) begin
      chData[i*DW +: DW] = {8'(i), src_seq[i]};
      chLast[i]          = last_auto ? last_of(i, src_seq[i]) : last_man[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NCH; i++)
      if (chValid[i] && chReady[i]) src_seq[i] <= src_seq[i] + 24'd1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (failure #%0d)", tag, obs, exp, n_fail);
    end
  endtask

  // One clock; afterwards score any beat that left the output register at that edge.
  task automatic tick();
    logic       pv, pr, pl, pt, prs, el;
    logic [1:0] pch;
    logic [31:0] pd;
    pv = outValid; pr = outReady; pl = outLast; pch = outCh; pd = outData;
    pt = terminate; prs = rst;
    @(posedge clk);
    #1;
    if (pv && !pr && !pt && prs)
      chk("hold", {outValid, outCh, outData, outLast}, {1'b1, pch, pd, pl});
    if (pv && pr) begin
      hs_cnt[pch]++;
      el = last_of(int'(pch), exp_seq[pch]);
      chk("data", pd, {8'(pch), exp_seq[pch]});
      if (last_auto) chk("last", pl, el);
      if (check_burst) begin
        if (open) chk("burst_ch", pch, cur_ch);
        else begin
          cur_ch  = int'(pch);
          run_len = 0;
        end
        run_len++;
        open = !(el || run_len == MB);
      end
      exp_seq[pch] = exp_seq[pch] + 24'd1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; terminate = 1'b0; chValid = '1;
    #1;
    chk("rst_chReady", chReady, 0);
    tick();
    tick();
    chValid = '0;
    rst = 1'b1;
    for (int i = 0; i < NCH; i++) exp_seq[i] = src_seq[i];
    open = 1'b0;
  endtask

  task automatic collect(input int n);
    obs_q = {};
    repeat (n) begin
      tick();
      obs_q.push_back(outValid ? int'(outCh) : -1);
    end
  endtask

  task automatic cmp_seq(input string tag);
    for (int i = 0; i < exp_q.size(); i++) chk(tag, obs_q[i], exp_q[i]);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; n_fail = 0;
    rst = 1'b0; terminate = 1'b0; chValid = '0; outReady = 1'b1;
    last_auto = 1'b0; last_man = '0; check_burst = 1'b0; open = 1'b0;
    cur_ch = 0; run_len = 0; hs0 = 0;
    for (int i = 0; i < NCH; i++) begin exp_seq[i] = '0; hs_cnt[i] = 0; end
    b_terminate = 1'b0; b_outReady = 1'b1; b_chValid = 4'b0001; b_chLast = '0;
    b_chData = {32'hB3, 32'hB2, 32'hB1, 32'hB0};

    // Reset values, then two-channel round robin with full 8-beat bursts.
    do_reset();
    chk("rst_out", {outValid, outLast, outCh, outData, busy, chReady}, 0);
    chValid = 4'b0110; last_man = '0; outReady = 1'b1;
    tick();
    chk("t1_grant", {busy, chReady}, {1'b1, 4'b0010});
    collect(10);
    exp_q = {1, 1, 1, 1, 1, 1, 1, 1, -1, 2};
    cmp_seq("t1_seq");

    // All channels valid, single-beat bursts.
    do_reset();
    chValid = 4'b1111; last_man = 4'b1111;
    tick();
    collect(9);
`ifdef CDC_RD_ARB_PRIO_EN
    exp_q = {0, -1, 0, -1, 0, -1, 0, -1, 0};
`else
    exp_q = {0, -1, 1, -1, 2, -1, 3, -1, 0};
`endif
    cmp_seq("t2_seq");

    // Downstream stall after the first beat of a ch3 burst.
    do_reset();
    chValid = 4'b1000; last_man = '0; outReady = 1'b1;
    tick();
    tick();
    chk("t3_first", {outValid, outCh, outData}, {1'b1, 2'd3, 8'd3, exp_seq[3] - 24'd0});
    hs0 = hs_cnt[3];
    outReady = 1'b0;
    repeat (5) begin
      #1;
      chk("t3_stall_rdy", chReady, 0);
      tick();
    end
    outReady = 1'b1;
    repeat (9) tick();
    chk("t3_burst_len", hs_cnt[3] - hs0, MB);

    // Terminate on the third beat of a ch2 burst; rotation pointer survives.
    do_reset();
    chValid = 4'b0100; last_man = '0; outReady = 1'b1;
    tick();
    tick();
    tick();
    terminate = 1'b1;
    #1;
    chk("t4_term_rdy", chReady, 0);
    tick();
    terminate = 1'b0;
    #1;
    chk("t4_after", {outValid, busy, chReady}, 0);
    chValid = 4'b1100;
    tick();
    chk("t4_regrant", {busy, chReady}, {1'b1, 4'b1000});
    tick();
    chk("t4_ch", {outValid, outCh}, {1'b1, 2'd3});

    // Channel 0 priority versus plain rotation.
    do_reset();
    chValid = 4'b1011; last_man = 4'b1111;
    tick();
    collect(7);
`ifdef CDC_RD_ARB_PRIO_EN
    exp_q = {0, -1, 0, -1, 0, -1, 0};
`else
    exp_q = {0, -1, 1, -1, 3, -1, 0};
`endif
    cmp_seq("t5_seq");

    // MAX_BURST=1 instance: one beat per grant, one idle cycle between grants.
    do_reset();
    tick();
    for (int k = 0; k < 6; k++) begin
      chk("b_busy", b_busy, (k % 2 == 0));
      chk("b_chReady", b_chReady, (k % 2 == 0) ? 4'b0001 : 4'b0000);
      if (k % 2 == 1) chk("b_out", {b_outValid, b_outCh, b_outData, b_outLast}, {1'b1, 2'd0, 32'hB0, 1'b0});
      else chk("b_ovalid", b_outValid, 0);
      tick();
    end

    // Randomized traffic and downstream backpressure.
    do_reset();
    last_auto = 1'b1; check_burst = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      chValid  = 4'($urandom);
      outReady = ($urandom_range(3) != 0);
      tick();
    end

    // Reset in the middle of traffic abandons the burst.
    chValid = '1;
    rst = 1'b0;
    #1;
    chk("mid_rst_rdy", chReady, 0);
    tick();
    chk("mid_rst_state", {busy, outValid, chReady}, 0);
    rst = 1'b1;
    check_burst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
